// File: rtl/arc4_encrypt_if.sv
// arc4_encrypt_if: start handshake, key and the three memory ports of the
// ARC4 encryption engine bundled as one interface.
//   en, key              start request and 24-bit key
//   rdy                  engine idle/ready
//   s_addr/s_wrdata/s_wren/s_rddata   256x8 S-box memory port
//   pt_addr/pt_rddata    plaintext read port (1-cycle latency)
//   ct_addr/ct_wrdata/ct_wren         ciphertext write port
// master: the side that requests runs and owns the memories.
// slave:  the engine itself.
interface arc4_encrypt_if;
    logic        en;
    logic        rdy;
    logic [23:0] key;
    logic [7:0]  s_addr;
    logic [7:0]  s_wrdata;
    logic        s_wren;
    logic [7:0]  s_rddata;
    logic [7:0]  pt_addr;
    logic [7:0]  pt_rddata;
    logic [7:0]  ct_addr;
    logic [7:0]  ct_wrdata;
    logic        ct_wren;

    modport master (
        output en, key, s_rddata, pt_rddata,
        input  rdy, s_addr, s_wrdata, s_wren, pt_addr, ct_addr, ct_wrdata, ct_wren
    );

    modport slave (
        input  en, key, s_rddata, pt_rddata,
        output rdy, s_addr, s_wrdata, s_wren, pt_addr, ct_addr, ct_wrdata, ct_wren
    );
endinterface

// File: rtl/arc4_encrypt.sv
// arc4_encrypt: ARC4 encryption engine. On an accepted en pulse it
// initialises the external S memory, runs the key schedule with the latched
// 24-bit key, then reads the length-prefixed plaintext and writes the
// length-prefixed ciphertext.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   bus          arc4_encrypt_if.slave (en/key/rdy plus S, pt and ct ports)
// Option macro ARC4_ENC_DROP256_EN: discard the first 256 keystream bytes
// (RC4-drop[256]) before producing ciphertext. Undefined gives plain ARC4.
// All memory-port outputs are registered; each state's outputs are computed
// on the edge that enters it, so a read address is visible in one state and
// its data is usable in the next.
module arc4_encrypt (
    input  logic          clk,
    input  logic          rst_n,
    arc4_encrypt_if.slave bus
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned KEY_W  = 24;
    localparam int unsigned KIDX_W = 2;

    typedef enum logic [4:0] {
        IDLE,
        INIT,
        KSA_RD_I,
        KSA_WAIT_I,
        KSA_RD_J,
        KSA_WAIT_J,
        KSA_WR_I,
        KSA_WR_J,
        LEN_RD,
        LEN_WR,
        P_RD_I,
        P_WAIT_I,
        P_RD_J,
        P_WAIT_J,
        P_WR_I,
        P_WR_J,
        P_RD_T,
        P_WAIT_T,
        DONE
    } state_t;

    state_t              state, state_n;
    logic [BYTE_W-1:0]   i, i_n;
    logic [BYTE_W-1:0]   j, j_n;
    logic [BYTE_W-1:0]   k, k_n;
    logic [BYTE_W-1:0]   len, len_n;
    logic [BYTE_W-1:0]   si, si_n;
    logic [BYTE_W-1:0]   sj, sj_n;
    logic [KIDX_W-1:0]   kidx, kidx_n;
    logic [KEY_W-1:0]    key_q, key_n;
    logic [BYTE_W-1:0]   key_byte;

    logic                rdy_q, rdy_n;
    logic [BYTE_W-1:0]   s_addr_q, s_addr_n;
    logic [BYTE_W-1:0]   s_wrdata_q, s_wrdata_n;
    logic                s_wren_q, s_wren_n;
    logic [BYTE_W-1:0]   pt_addr_q, pt_addr_n;
    logic [BYTE_W-1:0]   ct_addr_q, ct_addr_n;
    logic [BYTE_W-1:0]   ct_wrdata_q, ct_wrdata_n;
    logic                ct_wren_q, ct_wren_n;

`ifdef ARC4_ENC_DROP256_EN
    logic                drop_act, drop_act_n;
    logic [BYTE_W-1:0]   drop_cnt, drop_cnt_n;
`endif

    // Key byte picked by the explicit mod-3 counter.
    always_comb begin
        case (kidx)
            2'd0:    key_byte = key_q[23:16];
            2'd1:    key_byte = key_q[15:8];
            default: key_byte = key_q[7:0];
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            i           <= '0;
            j           <= '0;
            k           <= '0;
            len         <= '0;
            si          <= '0;
            sj          <= '0;
            kidx        <= '0;
            key_q       <= '0;
            rdy_q       <= 1'b1;
            s_addr_q    <= '0;
            s_wrdata_q  <= '0;
            s_wren_q    <= 1'b0;
            pt_addr_q   <= '0;
            ct_addr_q   <= '0;
            ct_wrdata_q <= '0;
            ct_wren_q   <= 1'b0;
`ifdef ARC4_ENC_DROP256_EN
            drop_act    <= 1'b0;
            drop_cnt    <= '0;
`endif
        end else begin
            state       <= state_n;
            i           <= i_n;
            j           <= j_n;
            k           <= k_n;
            len         <= len_n;
            si          <= si_n;
            sj          <= sj_n;
            kidx        <= kidx_n;
            key_q       <= key_n;
            rdy_q       <= rdy_n;
            s_addr_q    <= s_addr_n;
            s_wrdata_q  <= s_wrdata_n;
            s_wren_q    <= s_wren_n;
            pt_addr_q   <= pt_addr_n;
            ct_addr_q   <= ct_addr_n;
            ct_wrdata_q <= ct_wrdata_n;
            ct_wren_q   <= ct_wren_n;
`ifdef ARC4_ENC_DROP256_EN
            drop_act    <= drop_act_n;
            drop_cnt    <= drop_cnt_n;
`endif
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n     = state;
        i_n         = i;
        j_n         = j;
        k_n         = k;
        len_n       = len;
        si_n        = si;
        sj_n        = sj;
        kidx_n      = kidx;
        key_n       = key_q;
        s_addr_n    = s_addr_q;
        s_wrdata_n  = s_wrdata_q;
        s_wren_n    = 1'b0;
        pt_addr_n   = pt_addr_q;
        ct_addr_n   = ct_addr_q;
        ct_wrdata_n = ct_wrdata_q;
        ct_wren_n   = 1'b0;
`ifdef ARC4_ENC_DROP256_EN
        drop_act_n  = drop_act;
        drop_cnt_n  = drop_cnt;
`endif

        unique case (state)
            IDLE: begin
                if (bus.en) begin
                    key_n      = bus.key;
                    i_n        = '0;
                    j_n        = '0;
                    kidx_n     = '0;
                    s_addr_n   = '0;
                    s_wrdata_n = '0;
                    s_wren_n   = 1'b1;
                    state_n    = INIT;
                end
            end
            // s[i] = i is being written this cycle; queue the next one.
            INIT: begin
                if (i == 8'd255) begin
                    i_n      = '0;
                    s_addr_n = '0;
                    state_n  = KSA_RD_I;
                end else begin
                    i_n        = BYTE_W'(i + 8'd1);
                    s_addr_n   = BYTE_W'(i + 8'd1);
                    s_wrdata_n = BYTE_W'(i + 8'd1);
                    s_wren_n   = 1'b1;
                end
            end
            KSA_RD_I:   state_n = KSA_WAIT_I;
            KSA_WAIT_I: begin
                si_n     = bus.s_rddata;
                j_n      = BYTE_W'(j + bus.s_rddata + key_byte);
                s_addr_n = j_n;
                state_n  = KSA_RD_J;
            end
            KSA_RD_J:   state_n = KSA_WAIT_J;
            KSA_WAIT_J: begin
                s_addr_n   = i;
                s_wrdata_n = bus.s_rddata;
                s_wren_n   = 1'b1;
                state_n    = KSA_WR_I;
            end
            KSA_WR_I: begin
                s_addr_n   = j;
                s_wrdata_n = si;
                s_wren_n   = 1'b1;
                state_n    = KSA_WR_J;
            end
            KSA_WR_J: begin
                i_n    = BYTE_W'(i + 8'd1);
                kidx_n = (kidx == 2'd2) ? 2'd0 : KIDX_W'(kidx + 2'd1);
                if (i == 8'd255) begin
                    pt_addr_n = '0;
                    state_n   = LEN_RD;
                end else begin
                    s_addr_n = BYTE_W'(i + 8'd1);
                    state_n  = KSA_RD_I;
                end
            end
            LEN_RD:     state_n = LEN_WR;
            // Length byte arrives; copy it to ct[0] and start the keystream.
            LEN_WR: begin
                len_n       = bus.pt_rddata;
                ct_addr_n   = '0;
                ct_wrdata_n = bus.pt_rddata;
                ct_wren_n   = 1'b1;
                j_n         = '0;
                k_n         = 8'd1;
                if (bus.pt_rddata == 8'd0) begin
                    i_n     = '0;
                    state_n = DONE;
                end else begin
                    i_n      = 8'd1;
                    s_addr_n = 8'd1;
                    state_n  = P_RD_I;
`ifdef ARC4_ENC_DROP256_EN
                    drop_act_n = 1'b1;
                    drop_cnt_n = '0;
`endif
                end
            end
            P_RD_I:     state_n = P_WAIT_I;
            P_WAIT_I: begin
                si_n     = bus.s_rddata;
                j_n      = BYTE_W'(j + bus.s_rddata);
                s_addr_n = j_n;
                state_n  = P_RD_J;
            end
            P_RD_J:     state_n = P_WAIT_J;
            P_WAIT_J: begin
                sj_n       = bus.s_rddata;
                s_addr_n   = i;
                s_wrdata_n = bus.s_rddata;
                s_wren_n   = 1'b1;
                state_n    = P_WR_I;
            end
            P_WR_I: begin
                s_addr_n   = j;
                s_wrdata_n = si;
                s_wren_n   = 1'b1;
                state_n    = P_WR_J;
            end
            // Swap done; either discard this keystream byte or fetch it.
            P_WR_J: begin
`ifdef ARC4_ENC_DROP256_EN
                if (drop_act) begin
                    drop_cnt_n = BYTE_W'(drop_cnt + 8'd1);
                    if (drop_cnt == 8'd255) begin
                        drop_act_n = 1'b0;
                    end
                    i_n      = BYTE_W'(i + 8'd1);
                    s_addr_n = BYTE_W'(i + 8'd1);
                    state_n  = P_RD_I;
                end else begin
`endif
                    s_addr_n  = BYTE_W'(si + sj);
                    pt_addr_n = k;
                    state_n   = P_RD_T;
`ifdef ARC4_ENC_DROP256_EN
                end
`endif
            end
            P_RD_T:     state_n = P_WAIT_T;
            P_WAIT_T: begin
                ct_addr_n   = k;
                ct_wrdata_n = bus.pt_rddata ^ bus.s_rddata;
                ct_wren_n   = 1'b1;
                if (k == len) begin
                    state_n = DONE;
                end else begin
                    k_n      = BYTE_W'(k + 8'd1);
                    i_n      = BYTE_W'(i + 8'd1);
                    s_addr_n = BYTE_W'(i + 8'd1);
                    state_n  = P_RD_I;
                end
            end
            DONE:       state_n = IDLE;
            default:    state_n = IDLE;
        endcase

        rdy_n = (state_n == IDLE);
    end

    assign bus.rdy       = rdy_q;
    assign bus.s_addr    = s_addr_q;
    assign bus.s_wrdata  = s_wrdata_q;
    assign bus.s_wren    = s_wren_q;
    assign bus.pt_addr   = pt_addr_q;
    assign bus.ct_addr   = ct_addr_q;
    assign bus.ct_wrdata = ct_wrdata_q;
    assign bus.ct_wren   = ct_wren_q;

endmodule

// File: tb/tb_arc4_encrypt.sv
// tb_arc4_encrypt: bench for arc4_encrypt with behavioural S/pt/ct memories,
// a software ARC4 reference and an in-order ciphertext write scoreboard.
module tb_arc4_encrypt;

`ifdef ARC4_ENC_DROP256_EN
    localparam int DROP_EXTRA = 1536;
`else
    localparam int DROP_EXTRA = 0;
`endif

    logic clk;
    logic rst_n;
    logic ct_clr;

    int checks;
    int failures;

    logic [7:0]  s_mem  [256];
    logic [7:0]  pt_mem [256];
    logic [7:0]  ct_mem [256];
    logic [7:0]  exp_ct [256];
    logic [15:0] exp_q  [$];
    logic [7:0]  last_ct_addr;

    arc4_encrypt_if bus ();

    arc4_encrypt dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memories with one-cycle read latency.
    always @(posedge clk) begin
        if (bus.s_wren) s_mem[bus.s_addr] <= bus.s_wrdata;
        bus.s_rddata  <= s_mem[bus.s_addr];
        bus.pt_rddata <= pt_mem[bus.pt_addr];
    end

    always @(posedge clk) begin
        if (ct_clr) begin
            for (int a = 0; a < 256; a++) ct_mem[a] <= 8'h00;
        end else if (bus.ct_wren) begin
            ct_mem[bus.ct_addr] <= bus.ct_wrdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Every ciphertext write must be the next expected one; ports never overlap.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.s_wren || bus.ct_wren)
                check("wren_exclusive", 32'(bus.s_wren & bus.ct_wren), 32'd0);
            if (bus.ct_wren) begin
                if (exp_q.size() == 0) begin
                    check("ct_extra_write", 32'(exp_q.size()), 32'd1);
                end else begin
                    check($sformatf("ct_write_addr%0d", bus.ct_addr),
                          32'({bus.ct_addr, bus.ct_wrdata}), 32'(exp_q.pop_front()));
                    last_ct_addr = bus.ct_addr;
                end
            end
        end
    end

    // Software ARC4 over the current plaintext memory.
    task automatic build_expected(input logic [23:0] key);
        int s [256];
        int kb [3];
        int ii, jj, t, ks, len;
        kb[0] = int'(key[23:16]);
        kb[1] = int'(key[15:8]);
        kb[2] = int'(key[7:0]);
        for (int x = 0; x < 256; x++) s[x] = x;
        jj = 0;
        for (int x = 0; x < 256; x++) begin
            jj = (jj + s[x] + kb[x % 3]) % 256;
            t = s[x]; s[x] = s[jj]; s[jj] = t;
        end
        len = int'(pt_mem[0]);
        exp_q.delete();
        exp_ct[0] = pt_mem[0];
        exp_q.push_back({8'h00, pt_mem[0]});
        ii = 0;
        jj = 0;
`ifdef ARC4_ENC_DROP256_EN
        if (len > 0) begin
            for (int d = 0; d < 256; d++) begin
                ii = (ii + 1) % 256;
                jj = (jj + s[ii]) % 256;
                t = s[ii]; s[ii] = s[jj]; s[jj] = t;
            end
        end
`endif
        for (int n = 1; n <= len; n++) begin
            ii = (ii + 1) % 256;
            jj = (jj + s[ii]) % 256;
            t = s[ii]; s[ii] = s[jj]; s[jj] = t;
            ks = s[(s[ii] + s[jj]) % 256];
            exp_ct[n] = pt_mem[n] ^ 8'(ks);
            exp_q.push_back({8'(n), exp_ct[n]});
        end
    endtask

    // One run: pulse en, count busy cycles, then check ct memory.
    task automatic run_case(input string tag, input logic [23:0] key,
                            input int busy_exp, input bit second_pulse);
        int cycles;
        int len;
        len = int'(pt_mem[0]);
        build_expected(key);
        @(negedge clk) ct_clr = 1'b1;
        @(negedge clk) ct_clr = 1'b0;
        bus.key = key;
        bus.en  = 1'b1;
        @(negedge clk);
        bus.en  = 1'b0;
        cycles  = 0;
        while (bus.rdy == 1'b0 && cycles < 8000) begin
            cycles++;
            bus.en = second_pulse && (cycles == 490);
            @(negedge clk);
        end
        bus.en = 1'b0;
        check({tag, "_busy"}, 32'(cycles), 32'(busy_exp));
        check({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
        for (int a = 0; a <= len; a++)
            check($sformatf("%s_ct%0d", tag, a), 32'(ct_mem[a]), 32'(exp_ct[a]));
    endtask

    initial begin
        string msg;
        logic [7:0] lit [9];
        checks       = 0;
        failures     = 0;
        ct_clr       = 1'b0;
        last_ct_addr = 8'h00;
        bus.en       = 1'b0;
        bus.key      = 24'h0;
        for (int a = 0; a < 256; a++) pt_mem[a] = 8'h00;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_rdy",       32'(bus.rdy),       32'd1);
        check("rst_s_addr",    32'(bus.s_addr),    32'd0);
        check("rst_s_wrdata",  32'(bus.s_wrdata),  32'd0);
        check("rst_s_wren",    32'(bus.s_wren),    32'd0);
        check("rst_pt_addr",   32'(bus.pt_addr),   32'd0);
        check("rst_ct_addr",   32'(bus.ct_addr),   32'd0);
        check("rst_ct_wrdata", 32'(bus.ct_wrdata), 32'd0);
        check("rst_ct_wren",   32'(bus.ct_wren),   32'd0);

        // Key "Key", plaintext "Plaintext".
        msg = "Plaintext";
        pt_mem[0] = 8'd9;
        for (int n = 0; n < 9; n++) pt_mem[n + 1] = msg[n];
`ifndef ARC4_ENC_DROP256_EN
        build_expected(24'h4B6579);
        lit = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
        for (int n = 0; n < 9; n++)
            check($sformatf("model_pin%0d", n + 1), 32'(exp_ct[n + 1]), 32'(lit[n]));
        exp_q.delete();
`endif
        run_case("key_plaintext", 24'h4B6579, 1867 + DROP_EXTRA, 1'b0);

        // Empty message.
        pt_mem[0] = 8'd0;
        run_case("len0", 24'h000000, 1795, 1'b0);

        // Second en mid-run is ignored; no further run afterwards.
        pt_mem[0] = 8'd9;
        run_case("double_en", 24'h4B6579, 1867 + DROP_EXTRA, 1'b1);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("idle_after_run_rdy", 32'(bus.rdy), 32'd1);
        end

        // Reset while the key schedule is running.
        exp_q.delete();
        bus.key = 24'h4B6579;
        bus.en  = 1'b1;
        @(negedge clk);
        bus.en  = 1'b0;
        repeat (899) @(negedge clk);
        check("mid_run_busy", 32'(bus.rdy), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_rdy",     32'(bus.rdy),     32'd1);
        check("async_rst_s_wren",  32'(bus.s_wren),  32'd0);
        check("async_rst_ct_wren", 32'(bus.ct_wren), 32'd0);
        check("async_rst_s_addr",  32'(bus.s_addr),  32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        run_case("after_reset", 24'h4B6579, 1867 + DROP_EXTRA, 1'b0);

        // Full-length message with an all-ones key.
        pt_mem[0] = 8'd255;
        for (int n = 1; n < 256; n++) pt_mem[n] = 8'(n * 37 + 11);
        run_case("len255", 24'hFFFFFF, 3835 + DROP_EXTRA, 1'b0);
        check("len255_last_addr", 32'(last_ct_addr), 32'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule

// File: doc/arc4_encrypt.md
# arc4_encrypt

ARC4 encryption engine that reads a length-prefixed plaintext from a synchronous on-chip memory and writes the length-prefixed ciphertext into the ciphertext memory that the crack path later reads. Starts on a one-cycle `en` pulse while `rdy` is high. Runs the full ARC4 schedule (init, KSA, PRGA) against an external 256×8 S memory. Used to generate test ciphertexts on-board for the cracking datapath.

## Interface
Parameters:
- none

Ports:
- `clk` in 1: system clock, all logic on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `en` in 1: start request, sampled only while `rdy`=1
- `rdy` out 1: idle/ready; reset value 1
- `key` in 24: ARC4 key, captured on accepted `en`; byte0=`key[23:16]`, byte1=`key[15:8]`, byte2=`key[7:0]`
- `s_addr` out 8 / `s_wrdata` out 8 / `s_wren` out 1: S memory port; reset values 0/0/0
- `s_rddata` in 8: S read data, valid 1 cycle after address
- `pt_addr` out 8: plaintext read address; reset value 0
- `pt_rddata` in 8: plaintext data, 1-cycle read latency
- `ct_addr` out 8 / `ct_wrdata` out 8 / `ct_wren` out 1: ciphertext write port; reset values 0/0/0

## Operation
- Memory layout: `pt[0]` = length L (0..255), `pt[1..L]` = message; engine writes `ct[0]`=L, `ct[k]`=`pt[k]` XOR keystream byte k, for k=1..L.
- States:
  - IDLE: `rdy`=1. Accepted `en` latches `key`, sets i=0, j=0, and goes to INIT.
  - INIT: writes `s[i]`=i for i=0..255, one write per cycle. Goes to KSA.
  - KSA: i=0..255, six cycles per i: RD_I, WAIT_I, RD_J (j = j + s[i] + key byte (i mod 3), then address j), WAIT_J, WR_I (`s[i]`←s[j]), WR_J (`s[j]`←old s[i]). Goes to LEN.
  - LEN: reads `pt[0]`, writes `ct[0]`=L, clears i and j to 0, sets k=1. If L=0, goes to DONE; otherwise goes to PRGA.
  - PRGA: eight cycles per byte. The sequence is i=i+1, read s[i]; j=j+s[i], read s[j]; swap; read s[(s[i]+s[j]) mod 256] and `pt[k]` in parallel; write `ct[k]`. k increments; after k=L, goes to DONE.
  - DONE: one cycle, then returns to IDLE with `rdy`=1.
- Arithmetic: i, j, and the S index sum are all 8-bit and wrap mod 256. The key index is an explicit mod-3 counter (0,1,2,0...), not i%3 arithmetic.
- `en` while `rdy`=0 is ignored. `en` held high in IDLE starts exactly one run per IDLE entry.
- At most one of `s_wren` and `ct_wren` is asserted in any cycle, and each for one cycle per write.
- Reset mid-run: all state returns to IDLE and all outputs return to their reset values immediately (asynchronously). Memory contents are left as-is and are not restored.

## Timing
- Accepted `en` at edge N: `rdy`=0 from N+1.
- Busy cycles (`rdy`=0) total 256 + 1536 + 2 + 8·L + 1 (DONE).
- For L=9, `rdy` is low for exactly 1867 cycles.
- `ct[k]` write occurs in the last cycle of byte k's PRGA slot. Ciphertext bytes are written in ascending address order.
- No combinational path from `en` to `rdy`.

## Configuration
- `ARC4_ENC_DROP256_EN` defined: after LEN, run 256 PRGA iterations that update i, j and S but produce no `ct` writes (RC4-drop[256]). This adds exactly 6·256 cycles: read/swap only, no output read.
- Not defined (default): standard ARC4. This mode is required for compatibility with the crack path.

## Test plan
- Key 0x4B6579 ("Key"), pt = {9,"Plaintext"} → ct = {09, BB F3 16 E8 D9 40 AF 0A D3}; `rdy` low 1867 cycles.
- L=0, key 0x000000 → only `ct[0]`=00 written; no other `ct_wren`; `rdy` low 1795 cycles.
- `en` pulsed at cycles 10 and 500 of a run → single run; second pulse ignored; `ct` matches single-run result.
- `rst_n` low during KSA (cycle 900) → `rdy`=1 and all `*_wren`=0 immediately. A fresh run afterwards produces correct ct.
- L=255, key 0xFFFFFF → ct matches software ARC4 model; i/j wraparound exercised; last write at `ct_addr`=FF.
- With `ARC4_ENC_DROP256_EN`, key 0x4B6579, "Plaintext" → ct matches software RC4-drop[256] model; busy = 1867 + 1536 cycles.
